// File: rtl/serial_bus_arbiter.sv
// serial_bus_arbiter: grants a serial bus to one of NUM_MASTERS requesters with timeout and turnaround gap.
// Define ARB_ROUND_ROBIN_EN for round-robin arbitration; fixed lowest-index priority otherwise.
module serial_bus_arbiter #(
    parameter int NUM_MASTERS = 3,
    parameter int TIMEOUT_LEN = 6
) (
    input  logic                   clk,
    input  logic                   rstn,
    input  logic [NUM_MASTERS-1:0] b_request,
    input  logic                   bus_util,
    output logic [NUM_MASTERS-1:0] b_grant,
    output logic [1:0]             grant_id,
    output logic                   arb_busy,
    output logic                   timeout_pulse,
    output logic [3:0]             state
);
    localparam logic [1:0] IDLE      = 2'd0;
    localparam logic [1:0] WAIT_UTIL = 2'd1;
    localparam logic [1:0] BUSY      = 2'd2;
    localparam logic [1:0] RELEASE   = 2'd3;

    logic [1:0]             st;
    logic [1:0]             nxt;
    logic                   to;
    logic [1:0]             win;
    logic [TIMEOUT_LEN-1:0] timer;

`ifdef ARB_ROUND_ROBIN_EN
    localparam logic [2:0] NM = 3'(NUM_MASTERS);
    logic [1:0] ptr;
    logic [2:0] sum;
    // Scan downwards so the requester closest to the pointer is assigned last and wins.
    always_comb begin
        win = '0;
        sum = '0;
        for (int i = NUM_MASTERS - 1; i >= 0; i--) begin
            sum = {1'b0, ptr} + 3'(i);
            sum = (sum >= NM) ? sum - NM : sum;
            if (b_request[sum[1:0]]) win = sum[1:0];
        end
    end
    always_ff @(posedge clk or negedge rstn)
        if (!rstn) ptr <= '0;
        else if (nxt == RELEASE) ptr <= ({1'b0, grant_id} == NM - 3'd1) ? 2'd0 : grant_id + 2'd1;
`else
    always_comb begin
        win = '0;
        for (int i = NUM_MASTERS - 1; i >= 0; i--)
            if (b_request[i]) win = 2'(i);
    end
`endif

    always_comb begin
        nxt = IDLE;
        to  = 1'b0;
        case (st)
            IDLE:      nxt = |b_request ? WAIT_UTIL : IDLE;
            WAIT_UTIL: begin
                nxt = !bus_util ? BUSY : !(|(b_request & b_grant)) ? RELEASE : (&timer) ? RELEASE : WAIT_UTIL;
                to  = bus_util && |(b_request & b_grant) && (&timer);
            end
            BUSY:      nxt = bus_util ? RELEASE : BUSY;
            default:   nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            st            <= IDLE;
            b_grant       <= '0;
            grant_id      <= '0;
            timer         <= '0;
            timeout_pulse <= 1'b0;
        end else begin
            st            <= nxt;
            timeout_pulse <= to;
            if (st == IDLE && nxt == WAIT_UTIL) begin
                b_grant  <= NUM_MASTERS'(1) << win;
                grant_id <= win;
                timer    <= '0;
            end else if (nxt == RELEASE) begin
                b_grant <= '0;
            end
            if (st == WAIT_UTIL && nxt == WAIT_UTIL) timer <= timer + TIMEOUT_LEN'(1);
        end
    end

    assign arb_busy = st != IDLE;
    assign state    = {2'b00, st};
endmodule

// File: tb/tb_serial_bus_arbiter.sv
// tb_serial_bus_arbiter: directed scenario tests for serial_bus_arbiter (NUM_MASTERS=3, TIMEOUT_LEN=4).
module tb_serial_bus_arbiter;
    logic       clk = 1'b0;
    logic       rstn = 1'b0;
    logic [2:0] b_request = 3'b000;
    logic       bus_util = 1'b1;
    logic [2:0] b_grant;
    logic [1:0] grant_id;
    logic       arb_busy;
    logic       timeout_pulse;
    logic [3:0] state;
    int         n_chk = 0;
    int         n_fail = 0;

    serial_bus_arbiter #(.NUM_MASTERS(3), .TIMEOUT_LEN(4)) dut (
        .clk(clk), .rstn(rstn), .b_request(b_request), .bus_util(bus_util),
        .b_grant(b_grant), .grant_id(grant_id), .arb_busy(arb_busy),
        .timeout_pulse(timeout_pulse), .state(state)
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        rstn = 1'b0;
        b_request = 3'b111;
        tick();
        tick();
        n_chk++; if (b_grant !== 3'b000) begin n_fail++; $display("FAIL reset_grant: got %b want 000", b_grant); end
        n_chk++; if (state !== 4'd0) begin n_fail++; $display("FAIL reset_state: got %0d want 0", state); end
        n_chk++; if (grant_id !== 2'd0) begin n_fail++; $display("FAIL reset_id: got %0d want 0", grant_id); end
        n_chk++; if ({arb_busy, timeout_pulse} !== 2'b00) begin n_fail++; $display("FAIL reset_flags: got %b want 00", {arb_busy, timeout_pulse}); end
        b_request = 3'b000;
        rstn = 1'b1;
        tick();
    endtask

    task automatic test_single;
        b_request = 3'b010;
        tick();
        n_chk++; if (b_grant !== 3'b010 || grant_id !== 2'd1) begin n_fail++; $display("FAIL single_grant: got %b/%0d want 010/1", b_grant, grant_id); end
        n_chk++; if (state !== 4'd1 || arb_busy !== 1'b1) begin n_fail++; $display("FAIL single_wait: got state %0d busy %b want 1/1", state, arb_busy); end
        bus_util = 1'b0;
        b_request = 3'b101;
        for (int i = 0; i < 20; i++) begin
            tick();
            n_chk++; if (b_grant !== 3'b010 || state !== 4'd2) begin n_fail++; $display("FAIL single_hold[%0d]: got %b state %0d want 010 state 2", i, b_grant, state); end
        end
        b_request = 3'b000;
        bus_util = 1'b1;
        tick();
        n_chk++; if (state !== 4'd3 || b_grant !== 3'b000 || grant_id !== 2'd1) begin n_fail++; $display("FAIL single_release: got state %0d grant %b id %0d want 3/000/1", state, b_grant, grant_id); end
        tick();
        n_chk++; if (state !== 4'd0 || b_grant !== 3'b000 || grant_id !== 2'd1) begin n_fail++; $display("FAIL single_idle: got state %0d grant %b id %0d want 0/000/1", state, b_grant, grant_id); end
        tick();
        n_chk++; if (state !== 4'd0 || arb_busy !== 1'b0) begin n_fail++; $display("FAIL idle_no_req: got state %0d busy %b want 0/0", state, arb_busy); end
    endtask

    task automatic test_timeout;
        int cnt = 0;
        b_request = 3'b001;
        bus_util = 1'b1;
        tick();
        while (b_grant === 3'b001 && cnt < 40) begin
            cnt++;
            n_chk++; if (timeout_pulse !== 1'b0) begin n_fail++; $display("FAIL early_pulse: cycle %0d pulse %b want 0", cnt, timeout_pulse); end
            tick();
        end
        n_chk++; if (cnt != 16) begin n_fail++; $display("FAIL timeout_len: got %0d cycles want 16", cnt); end
        n_chk++; if (timeout_pulse !== 1'b1 || state !== 4'd3 || b_grant !== 3'b000) begin n_fail++; $display("FAIL timeout_release: got pulse %b state %0d grant %b want 1/3/000", timeout_pulse, state, b_grant); end
        b_request = 3'b000;
        tick();
        n_chk++; if (timeout_pulse !== 1'b0 || state !== 4'd0) begin n_fail++; $display("FAIL timeout_idle: got pulse %b state %0d want 0/0", timeout_pulse, state); end
    endtask

    task automatic test_contention;
`ifdef ARB_ROUND_ROBIN_EN
        int exp_id[4] = '{0, 1, 2, 0};
`else
        int exp_id[4] = '{0, 0, 0, 0};
`endif
        logic [2:0] exp_g;
        #2 rstn = 1'b0;
        #2 rstn = 1'b1;
        tick();
        b_request = 3'b111;
        bus_util = 1'b1;
        for (int t = 0; t < 4; t++) begin
            tick();
            exp_g = 3'b001 << exp_id[t];
            n_chk++; if (grant_id !== 2'(exp_id[t]) || b_grant !== exp_g) begin n_fail++; $display("FAIL contention[%0d]: got id %0d grant %b want %0d/%b", t, grant_id, b_grant, exp_id[t], exp_g); end
            bus_util = 1'b0;
            tick();
            bus_util = 1'b1;
            tick();
            n_chk++; if (b_grant !== 3'b000 || state !== 4'd3) begin n_fail++; $display("FAIL contention_gap[%0d]: got grant %b state %0d want 000/3", t, b_grant, state); end
            tick();
        end
        b_request = 3'b000;
        tick();
    endtask

    task automatic test_simultaneous;
        b_request = 3'b001;
        tick();
        b_request = 3'b000;
        bus_util = 1'b0;
        tick();
        n_chk++; if (state !== 4'd2 || b_grant !== 3'b001) begin n_fail++; $display("FAIL simultaneous: got state %0d grant %b want 2/001", state, b_grant); end
        bus_util = 1'b1;
        tick();
        tick();
        n_chk++; if (state !== 4'd0) begin n_fail++; $display("FAIL simultaneous_idle: got state %0d want 0", state); end
    endtask

    task automatic test_reset_mid_busy;
        b_request = 3'b010;
        tick();
        bus_util = 1'b0;
        tick();
        n_chk++; if (state !== 4'd2) begin n_fail++; $display("FAIL midbusy_setup: got state %0d want 2", state); end
        #2 rstn = 1'b0;
        #1;
        n_chk++; if (b_grant !== 3'b000 || state !== 4'd0 || grant_id !== 2'd0) begin n_fail++; $display("FAIL async_reset: got grant %b state %0d id %0d want 000/0/0", b_grant, state, grant_id); end
        #2 rstn = 1'b1;
        bus_util = 1'b1;
        b_request = 3'b100;
        tick();
        n_chk++; if (b_grant !== 3'b100 || grant_id !== 2'd2 || state !== 4'd1) begin n_fail++; $display("FAIL post_reset_grant: got %b id %0d state %0d want 100/2/1", b_grant, grant_id, state); end
        b_request = 3'b000;
        tick();
        tick();
        b_request = 3'b111;
        tick();
        n_chk++; if (b_grant !== 3'b001 || grant_id !== 2'd0) begin n_fail++; $display("FAIL pointer_wrap: got %b id %0d want 001/0", b_grant, grant_id); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_timeout();
        test_contention();
        test_simultaneous();
        test_reset_mid_busy();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
